// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared widths and ID/EX register layout for the RV32I pipeline
package pipeline_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int CTRL_W = 16;

  typedef struct packed {
    logic              valid;
    logic              reg_write;
    logic              mem_read;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   rs1_val;
    logic [XLEN-1:0]   rs2_val;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   imm;
    logic [CTRL_W-1:0] ctrl;
  } id_ex_t;

  localparam id_ex_t BUBBLE = '0;

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - load-use hazard detection between ID and an in-flight load in EX
module hazard_detect (
  input  logic       id_valid_i,
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  input  logic       ex_valid_i,
  input  logic       ex_mem_read_i,
  input  logic [4:0] ex_rd_i,
  output logic       lu_o
);

  // rs2 is compared even for instructions that ignore it; a false hit only costs a bubble
  assign lu_o = id_valid_i && ex_valid_i && ex_mem_read_i && (ex_rd_i != 5'd0) &&
                ((ex_rd_i == id_rs1_i) || (ex_rd_i == id_rs2_i));

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with WB bypass, load-use bubbles and stall counter
module id_ex_stage #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic [4:0]        id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [XLEN-1:0]   rf_rd1,
  input  logic [XLEN-1:0]   rf_rd2,
  input  logic              wb_we,
  input  logic [4:0]        wb_rd,
  input  logic [XLEN-1:0]   wb_wd,
  input  logic              flush,
  input  logic              hold,
  output logic              load_use_stall,
  output logic              ex_valid,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic [4:0]        ex_rs1,
  output logic [4:0]        ex_rs2,
  output logic [4:0]        ex_rd,
  output logic [XLEN-1:0]   ex_rs1_val,
  output logic [XLEN-1:0]   ex_rs2_val,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_imm,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [CNT_W-1:0]  stall_count
);

  import pipeline_pkg::*;

  logic [XLEN-1:0]  op1, op2;
  logic             lu;
  id_ex_t           ex_q, ex_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The register file writes on the edge but reads combinationally, so same-cycle WB data is forwarded
  always_comb begin
    op1 = rf_rd1;
    if (id_rs1 == 5'd0)                     op1 = '0;
    else if (wb_we && (wb_rd == id_rs1))    op1 = wb_wd;
    op2 = rf_rd2;
    if (id_rs2 == 5'd0)                     op2 = '0;
    else if (wb_we && (wb_rd == id_rs2))    op2 = wb_wd;
  end

  hazard_detect u_hazard (
    .id_valid_i    (id_valid),
    .id_rs1_i      (id_rs1),
    .id_rs2_i      (id_rs2),
    .ex_valid_i    (ex_q.valid),
    .ex_mem_read_i (ex_q.mem_read),
    .ex_rd_i       (ex_q.rd),
    .lu_o          (lu)
  );

  assign load_use_stall = lu && !flush && !hold;

  always_comb begin
    ex_d  = ex_q;
    cnt_d = cnt_q;
    if (flush) begin
      ex_d = BUBBLE;
    end else if (hold) begin
      // Refresh held operands so a long hold does not leave EX with stale register values
      if (ex_q.valid && wb_we && (wb_rd != 5'd0)) begin
        if (wb_rd == ex_q.rs1) ex_d.rs1_val = wb_wd;
        if (wb_rd == ex_q.rs2) ex_d.rs2_val = wb_wd;
      end
    end else if (lu) begin
      ex_d = BUBBLE;
      if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
    end else begin
      ex_d.valid     = id_valid;
      ex_d.reg_write = id_valid && id_reg_write;
      ex_d.mem_read  = id_valid && id_mem_read;
      ex_d.rs1       = id_rs1;
      ex_d.rs2       = id_rs2;
      ex_d.rd        = id_rd;
      ex_d.rs1_val   = op1;
      ex_d.rs2_val   = op2;
      ex_d.pc        = id_pc;
      ex_d.imm       = id_imm;
      ex_d.ctrl      = id_ctrl;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q  <= BUBBLE;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      cnt_q <= cnt_d;
    end
  end

  assign ex_valid     = ex_q.valid;
  assign ex_reg_write = ex_q.reg_write;
  assign ex_mem_read  = ex_q.mem_read;
  assign ex_rs1       = ex_q.rs1;
  assign ex_rs2       = ex_q.rs2;
  assign ex_rd        = ex_q.rd;
  assign ex_rs1_val   = ex_q.rs1_val;
  assign ex_rs2_val   = ex_q.rs2_val;
  assign ex_pc        = ex_q.pc;
  assign ex_imm       = ex_q.imm;
  assign ex_ctrl      = ex_q.ctrl;
  assign stall_count  = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - randomized and directed bench for id_ex_stage against a rule-level model
module tb_id_ex_stage;

  localparam int CNT_MAX = 3;

  logic        clk, reset;
  logic        id_valid, id_reg_write, id_mem_read;
  logic [4:0]  id_rs1, id_rs2, id_rd, wb_rd;
  logic [15:0] id_ctrl;
  logic [31:0] id_pc, id_imm, rf_rd1, rf_rd2, wb_wd;
  logic        wb_we, flush, hold;
  logic        load_use_stall, ex_valid, ex_reg_write, ex_mem_read;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [31:0] ex_rs1_val, ex_rs2_val, ex_pc, ex_imm;
  logic [15:0] ex_ctrl;
  logic [1:0]  stall_count;

  int vectors = 0;
  int miscompares = 0;

  // expected EX-side state
  logic        m_valid, m_rw, m_mr;
  logic [4:0]  m_rs1, m_rs2, m_rd;
  logic [31:0] m_v1, m_v2, m_pc, m_imm;
  logic [15:0] m_ctrl;
  int          m_cnt;

  id_ex_stage #(.XLEN(32), .CTRL_W(16), .CNT_W(2)) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_ctrl(id_ctrl),
    .id_pc(id_pc), .id_imm(id_imm), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_wd(wb_wd), .flush(flush), .hold(hold),
    .load_use_stall(load_use_stall), .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val), .ex_pc(ex_pc), .ex_imm(ex_imm),
    .ex_ctrl(ex_ctrl), .stall_count(stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic m_clear();
    m_valid = 0; m_rw = 0; m_mr = 0; m_rs1 = 0; m_rs2 = 0; m_rd = 0;
    m_v1 = 0; m_v2 = 0; m_pc = 0; m_imm = 0; m_ctrl = 0; m_cnt = 0;
  endtask

  function automatic logic [31:0] operand(input logic [4:0] rs, input logic [31:0] rf);
    if (rs == 0) return 32'd0;
    if (wb_we && wb_rd == rs) return wb_wd;
    return rf;
  endfunction

  function automatic logic m_lu();
    return id_valid && m_valid && m_mr && m_rd != 0 && (m_rd == id_rs1 || m_rd == id_rs2);
  endfunction

  task automatic m_update();
    logic lu;
    lu = m_lu();
    if (flush) begin
      m_valid = 0; m_rw = 0; m_mr = 0; m_rs1 = 0; m_rs2 = 0; m_rd = 0;
      m_v1 = 0; m_v2 = 0; m_pc = 0; m_imm = 0; m_ctrl = 0;
    end else if (hold) begin
      if (m_valid && wb_we && wb_rd != 0) begin
        if (wb_rd == m_rs1) m_v1 = wb_wd;
        if (wb_rd == m_rs2) m_v2 = wb_wd;
      end
    end else if (lu) begin
      m_valid = 0; m_rw = 0; m_mr = 0; m_rs1 = 0; m_rs2 = 0; m_rd = 0;
      m_v1 = 0; m_v2 = 0; m_pc = 0; m_imm = 0; m_ctrl = 0;
      if (m_cnt < CNT_MAX) m_cnt++;
    end else begin
      m_v1 = operand(id_rs1, rf_rd1);
      m_v2 = operand(id_rs2, rf_rd2);
      m_valid = id_valid; m_rw = id_valid & id_reg_write; m_mr = id_valid & id_mem_read;
      m_rs1 = id_rs1; m_rs2 = id_rs2; m_rd = id_rd;
      m_pc = id_pc; m_imm = id_imm; m_ctrl = id_ctrl;
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".valid"}, 32'(ex_valid), 32'(m_valid));
    check({tag, ".rw"},    32'(ex_reg_write), 32'(m_rw));
    check({tag, ".mr"},    32'(ex_mem_read), 32'(m_mr));
    check({tag, ".rs1"},   32'(ex_rs1), 32'(m_rs1));
    check({tag, ".rs2"},   32'(ex_rs2), 32'(m_rs2));
    check({tag, ".rd"},    32'(ex_rd), 32'(m_rd));
    check({tag, ".v1"},    ex_rs1_val, m_v1);
    check({tag, ".v2"},    ex_rs2_val, m_v2);
    check({tag, ".pc"},    ex_pc, m_pc);
    check({tag, ".imm"},   ex_imm, m_imm);
    check({tag, ".ctrl"},  32'(ex_ctrl), 32'(m_ctrl));
    check({tag, ".cnt"},   32'(stall_count), 32'(m_cnt));
  endtask

  // inputs are driven just after a negedge; ends on the following negedge
  task automatic step(input string tag);
    #1;
    check({tag, ".lu"}, 32'(load_use_stall), 32'(m_lu() && !flush && !hold));
    @(posedge clk);
    m_update();
    #1;
    check_outputs(tag);
    @(negedge clk);
  endtask

  task automatic idle();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_reg_write = 0; id_mem_read = 0;
    id_ctrl = 0; id_pc = 0; id_imm = 0; rf_rd1 = 0; rf_rd2 = 0;
    wb_we = 0; wb_rd = 0; wb_wd = 0; flush = 0; hold = 0;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic rw, input logic mr);
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_reg_write = rw; id_mem_read = mr;
    id_ctrl = 16'($urandom); id_pc = $urandom; id_imm = $urandom;
    rf_rd1 = $urandom; rf_rd2 = $urandom;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    m_clear();
    repeat (2) @(negedge clk);
    check_outputs("reset");
    reset = 1'b0;

    // WB bypass, including x0 never bypassed
    set_id(1, 3, 0, 7, 1, 0); rf_rd1 = 32'h8;
    wb_we = 1; wb_rd = 3; wb_wd = 32'hAAAAAAAA;
    step("byp");
    check("byp_rs1", ex_rs1_val, 32'hAAAAAAAA);
    set_id(1, 0, 0, 7, 1, 0); rf_rd1 = 32'h1234; wb_rd = 0;
    step("byp0");
    check("byp_x0", ex_rs1_val, 32'h0);
    idle();

    // lw x5 followed by add x6, x5, x1
    set_id(1, 1, 0, 5, 1, 1); step("lw");
    set_id(1, 5, 1, 6, 1, 0);
    #1 check("lu_dir", 32'(load_use_stall), 32'd1);
    step("lu");
    check("lu_bubble", 32'(ex_valid), 32'd0);
    check("lu_cnt", 32'(stall_count), 32'd1);
    step("lu_next");
    check("lu_add_valid", 32'(ex_valid), 32'd1);
    check("lu_add_rd", 32'(ex_rd), 32'd6);

    // flush beats load-use
    set_id(1, 1, 0, 5, 1, 1); step("lw2");
    set_id(1, 5, 1, 6, 1, 0); flush = 1;
    #1 check("flush_lu", 32'(load_use_stall), 32'd0);
    step("flush");
    check("flush_valid", 32'(ex_valid), 32'd0);
    check("flush_cnt", 32'(stall_count), 32'd1);
    flush = 0;

    // held operand refreshed by WB
    set_id(1, 2, 4, 9, 1, 0); rf_rd2 = 32'h11; step("hload");
    hold = 1; set_id(1, 4, 4, 3, 1, 0);
    step("hold1");
    wb_we = 1; wb_rd = 4; wb_wd = 32'h55555555;
    step("hold2");
    check("hold_rs2_val", ex_rs2_val, 32'h55555555);
    check("hold_rd", 32'(ex_rd), 32'd9);
    wb_we = 0;
    step("hold3");
    idle();

    // saturation at 2 bits
    for (int i = 0; i < 5; i++) begin
      set_id(1, 1, 0, 5, 1, 1); step("sat_lw");
      set_id(1, 2, 5, 6, 1, 0); step("sat_lu");
    end
    check("sat_cnt", 32'(stall_count), 32'd3);

    // asynchronous reset mid-cycle with a valid instruction in EX
    set_id(1, 1, 2, 3, 1, 0); step("pre_rst");
    check("pre_rst_valid", 32'(ex_valid), 32'd1);
    #2 reset = 1'b1;
    m_clear();
    #1 check_outputs("async_rst");
    @(negedge clk);
    check_outputs("rst_held");
    reset = 1'b0;

    for (int i = 0; i < 400; i++) begin
      set_id($urandom_range(0, 9) != 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             5'($urandom_range(0, 7)), 1'($urandom), $urandom_range(0, 2) == 0);
      wb_we = 1'($urandom); wb_rd = 5'($urandom_range(0, 7)); wb_wd = $urandom;
      flush = $urandom_range(0, 9) == 0;
      hold = $urandom_range(0, 6) == 0;
      step("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
